// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I(+M) decode stage with valid/ready handshake, stall and flush.
module rv_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm,
    output logic             alu_src,
    output logic             alu_src_pc,
    output logic [4:0]       alu_cnt,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_size,
    output logic             mem_unsigned,
    output logic             branch,
    output logic             jump,
    output logic             jalr,
    output logic             link,
    output logic [2:0]       br_funct3,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count
);
    localparam logic [4:0] AND = 5'b00000, OR = 5'b00001, ADD = 5'b00010, PASSB = 5'b00011,
                           SUB = 5'b00110, SLT = 5'b00111, SRA = 5'b01000, SLTU = 5'b01001,
                           XOR = 5'b01100, SLL = 5'b01101, SRL = 5'b01110;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] imm;
        logic            alu_src, alu_src_pc;
        logic [4:0]      alu_cnt;
        logic            reg_write, mem_to_reg, mem_read, mem_write;
        logic [1:0]      mem_size;
        logic            mem_unsigned, branch, jump, jalr, link;
        logic [2:0]      br_funct3;
        logic            illegal;
    } bundle_t;
    bundle_t d, q;
    logic v, ill, accept;
    logic [CNT_W-1:0] cnt;
    logic [6:0] op, f7;
    logic [2:0] f3;
    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];
    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [4:0] alu_f3(input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  return alt ? SUB : ADD;
            3'b001:  return SLL;
            3'b010:  return SLT;
            3'b011:  return SLTU;
            3'b100:  return XOR;
            3'b101:  return alt ? SRA : SRL;
            3'b110:  return OR;
            default: return AND;
        endcase
    endfunction
    always_comb begin
        d = '0;
        ill = 1'b0;
        d.pc = in_pc;
        d.rs1 = in_instr[19:15];
        d.rs2 = in_instr[24:20];
        d.alu_cnt = ADD;
        case (op)
            7'b0110011: begin
                d.reg_write = 1'b1;
                d.mem_to_reg = 1'b1;
                d.alu_cnt = (ENABLE_M && f7 == 7'b0000001) ? {2'b10, f3} : alu_f3(f3, f7 == 7'b0100000);
                ill = !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                        || (ENABLE_M && f7 == 7'b0000001));
            end
            7'b0010011: begin
                d.alu_src = 1'b1;
                d.reg_write = 1'b1;
                d.mem_to_reg = 1'b1;
                d.imm = XLEN'($signed(in_instr[31:20]));
                d.alu_cnt = alu_f3(f3, f3 == 3'b101 && f7 == 7'b0100000);
                ill = (f3 == 3'b001 && f7 != 7'b0000000) ||
                      (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            7'b0000011: begin
                d.alu_src = 1'b1;
                d.mem_read = 1'b1;
                d.reg_write = 1'b1;
                d.mem_size = f3[1:0];
                d.mem_unsigned = f3[2];
                d.imm = XLEN'($signed(in_instr[31:20]));
                ill = f3[1:0] == 2'b11 || f3[2:1] == 2'b11;
            end
            7'b0100011: begin
                d.alu_src = 1'b1;
                d.mem_write = 1'b1;
                d.mem_size = f3[1:0];
                d.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                ill = f3 > 3'b010;
            end
            7'b1100011: begin
                d.branch = 1'b1;
                d.br_funct3 = f3;
                d.alu_cnt = f3[2] ? (f3[1] ? SLTU : SLT) : SUB;
                d.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
                ill = f3[2:1] == 2'b01;
            end
            7'b1101111: begin
                d.jump = 1'b1;
                d.link = 1'b1;
                d.alu_src_pc = 1'b1;
                d.alu_src = 1'b1;
                d.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
            end
            7'b1100111: begin
                d.jalr = 1'b1;
                d.link = 1'b1;
                d.alu_src = 1'b1;
                d.imm = XLEN'($signed(in_instr[31:20]));
                ill = f3 != 3'b000;
            end
            7'b0110111: begin
                d.alu_src = 1'b1;
                d.reg_write = 1'b1;
                d.alu_cnt = PASSB;
                d.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            7'b0010111: begin
                d.alu_src_pc = 1'b1;
                d.alu_src = 1'b1;
                d.reg_write = 1'b1;
                d.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            default: ill = 1'b1;
        endcase
        d.rd = d.reg_write ? in_instr[11:7] : 5'd0;
        if (ill) begin
            d = '0;
            d.pc = in_pc;
            d.illegal = 1'b1;
        end
    end
    assign in_ready = !v || out_ready;
    assign accept = in_valid && in_ready && !flush;
    // Cleared bundle on flush/drain keeps every enable low while out_valid=0
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            q <= '0;
            cnt <= '0;
        end else begin
            if (v && out_ready && !flush) cnt <= cnt + 1'b1;
            if (flush) begin
                v <= 1'b0;
                q <= '0;
            end else if (accept) begin
                v <= 1'b1;
                q <= d;
            end else if (out_ready) begin
                v <= 1'b0;
                q <= '0;
            end
        end
    end
    assign out_valid = v;
    assign out_pc = q.pc;
    assign rs1 = q.rs1;
    assign rs2 = q.rs2;
    assign rd = q.rd;
    assign imm = q.imm;
    assign alu_src = q.alu_src;
    assign alu_src_pc = q.alu_src_pc;
    assign alu_cnt = q.alu_cnt;
    assign reg_write = q.reg_write;
    assign mem_to_reg = q.mem_to_reg;
    assign mem_read = q.mem_read;
    assign mem_write = q.mem_write;
    assign mem_size = q.mem_size;
    assign mem_unsigned = q.mem_unsigned;
    assign branch = q.branch;
    assign jump = q.jump;
    assign jalr = q.jalr;
    assign link = q.link;
    assign br_funct3 = q.br_funct3;
    assign illegal = q.illegal;
    assign dec_count = cnt;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed-vector bench; u0 is the base config, u1 has ENABLE_M=1 and a 4-bit counter.
module tb_rv_decode_stage;
    logic clk = 1'b0, rst, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    int errors = 0, checks = 0;
    logic in_ready, out_valid, alu_src, alu_src_pc, reg_write, mem_to_reg, mem_read, mem_write;
    logic mem_unsigned, branch, jump, jalr, link, illegal;
    logic [31:0] out_pc, imm, dec_count;
    logic [4:0] rs1, rs2, rd, alu_cnt;
    logic [1:0] mem_size;
    logic [2:0] br_funct3;
    logic in_ready_m, out_valid_m, alu_src_m, alu_src_pc_m, reg_write_m, mem_to_reg_m, mem_read_m;
    logic mem_write_m, mem_unsigned_m, branch_m, jump_m, jalr_m, link_m, illegal_m;
    logic [31:0] out_pc_m, imm_m;
    logic [3:0] dec_count_m;
    logic [4:0] rs1_m, rs2_m, rd_m, alu_cnt_m;
    logic [1:0] mem_size_m;
    logic [2:0] br_funct3_m;

    always #5 clk = ~clk;

    rv_decode_stage u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_src(alu_src), .alu_src_pc(alu_src_pc),
        .alu_cnt(alu_cnt), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned), .branch(branch),
        .jump(jump), .jalr(jalr), .link(link), .br_funct3(br_funct3), .illegal(illegal),
        .dec_count(dec_count)
    );

    rv_decode_stage #(.ENABLE_M(1'b1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(out_valid_m), .out_ready(out_ready), .out_pc(out_pc_m),
        .rs1(rs1_m), .rs2(rs2_m), .rd(rd_m), .imm(imm_m), .alu_src(alu_src_m), .alu_src_pc(alu_src_pc_m),
        .alu_cnt(alu_cnt_m), .reg_write(reg_write_m), .mem_to_reg(mem_to_reg_m), .mem_read(mem_read_m),
        .mem_write(mem_write_m), .mem_size(mem_size_m), .mem_unsigned(mem_unsigned_m), .branch(branch_m),
        .jump(jump_m), .jalr(jalr_m), .link(link_m), .br_funct3(br_funct3_m), .illegal(illegal_m),
        .dec_count(dec_count_m)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc = pc;
        step();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'hFFF00093;
        in_pc = 32'h100;
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_count", dec_count, 0);
        check("rst_regwr", reg_write, 0);
        check("rst_illegal", illegal, 0);
        check("rst_imm", imm, 0);
        check("rst_inready", in_ready, 1);
        rst = 1'b0;

        send(32'hFFF00093, 32'h100);
        check("addi_valid", out_valid, 1);
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_alu", alu_cnt, 5'b00010);
        check("addi_src", alu_src, 1);
        check("addi_regwr", reg_write, 1);
        check("addi_rd", rd, 1);
        check("addi_pc", out_pc, 32'h100);
        check("addi_count", dec_count, 0);

        send(32'h0020E463, 32'h104);
        check("bltu_branch", branch, 1);
        check("bltu_f3", br_funct3, 3'b110);
        check("bltu_alu", alu_cnt, 5'b01001);
        check("bltu_imm", imm, 8);
        check("bltu_rd", rd, 0);
        check("bltu_rs", {rs1, rs2}, {5'd1, 5'd2});
        check("bltu_count", dec_count, 1);

        send(32'h123452B7, 32'h108);
        check("lui_imm", imm, 32'h12345000);
        check("lui_alu", alu_cnt, 5'b00011);
        check("lui_rd", rd, 5);
        out_ready = 1'b0;
        in_instr = 32'h00001517;
        in_pc = 32'h10C;
        #1;
        check("bp_inready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_valid", out_valid, 1);
            check("bp_pc", out_pc, 32'h108);
            check("bp_imm", imm, 32'h12345000);
            check("bp_rd", rd, 5);
            check("bp_inready", in_ready, 0);
            check("bp_count", dec_count, 2);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release", in_ready, 1);
        step();
        check("auipc_pc", out_pc, 32'h10C);
        check("auipc_srcpc", alu_src_pc, 1);
        check("auipc_rd", rd, 10);
        check("auipc_imm", imm, 32'h1000);
        check("auipc_count", dec_count, 3);

        flush = 1'b1;
        send(32'hFFF00093, 32'h110);
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_regwr", reg_write, 0);
        check("flush_count", dec_count, 3);

        send(32'h02208033, 32'h200);
        check("mul_valid", out_valid, 1);
        check("mul_illegal", illegal, 1);
        check("mul_regwr", reg_write, 0);
        check("mul_m_illegal", illegal_m, 0);
        check("mul_m_alu", alu_cnt_m, 5'b10000);
        check("mul_m_regwr", reg_write_m, 1);

        send(32'h0000007F, 32'h204);
        check("op7f_illegal", illegal, 1);
        check("op7f_valid", out_valid, 1);
        check("op7f_count", dec_count, 4);

        send(32'h0220D093, 32'h208);
        check("srai_bad", illegal, 1);
        send(32'h4020D093, 32'h20C);
        check("srai_ok", illegal, 0);
        check("srai_alu", alu_cnt, 5'b01000);

        send(32'hFFC15183, 32'h210);
        check("lhu_read", mem_read, 1);
        check("lhu_size", mem_size, 2'b01);
        check("lhu_uns", mem_unsigned, 1);
        check("lhu_m2r", mem_to_reg, 0);
        check("lhu_imm", imm, 32'hFFFFFFFC);
        check("lhu_rd", rd, 3);

        send(32'h0020A423, 32'h214);
        check("sw_write", mem_write, 1);
        check("sw_size", mem_size, 2'b10);
        check("sw_imm", imm, 8);
        check("sw_rd", rd, 0);

        send(32'h010000EF, 32'h218);
        check("jal_jump", jump, 1);
        check("jal_link", link, 1);
        check("jal_srcpc", alu_src_pc, 1);
        check("jal_imm", imm, 16);
        check("jal_count", dec_count, 9);

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_valid", out_valid, 0);
        check("rst2_count", dec_count_m, 0);
        for (int k = 0; k < 17; k++) send(32'h00000013, 32'h300 + 4 * k);
        in_valid = 1'b0;
        step();
        check("wrap_count_m", dec_count_m, 1);
        check("wrap_count", dec_count, 17);
        check("wrap_drain", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Registered ID stage for the RV32I pipeline, succeeding the combinational main/ALU control decoders. It accepts fetched instructions over a valid/ready handshake and performs full RV32I decode, with the M extension optional. It generates control, ALU code and sign-extended immediate, and presents them one cycle later through a single-entry pipeline register with stall and flush. It sits between the IF stage and the register-file read / EX stage.

Parameters:
XLEN, 32, datapath width of pc and imm (32 or 64; decode is RV32I encodings only)
ENABLE_M, 0, 1 = decode MUL/DIV/REM (funct7=0000001); 0 = those encodings are illegal
CNT_W, 32, width of decoded-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction/pc valid from IF
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
flush  in  1  kill held and incoming instruction (branch mispredict/trap)
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts bundle
out_pc  out  XLEN  pc of held instruction
rs1, rs2, rd  out  5 each  register indices (rd forced 0 when reg_write=0)
imm  out  XLEN  sign-extended immediate (I/S/B/U/J per opcode)
alu_src  out  1  operand B = imm
alu_src_pc  out  1  operand A = pc (AUIPC, JAL)
alu_cnt  out  5  ALU operation code
reg_write, mem_to_reg, mem_read, mem_write  out  1 each  as in existing control
mem_size  out  2  00 byte, 01 half, 10 word
mem_unsigned  out  1  LBU/LHU
branch, jump, jalr, link  out  1 each  flow control
br_funct3  out  3  branch condition (funct3 passthrough)
illegal  out  1  unsupported encoding
dec_count  out  CNT_W  instructions handed to EX

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, every 1-bit output=0, all buses=0, dec_count=0. Reset mid-handshake drops the held bundle.
- in_ready = !out_valid || out_ready (combinational; not gated by flush).
- Accept = in_valid && in_ready && !flush. On accept, the register loads the decoded bundle and out_valid=1 next cycle. Latency: exactly 1 cycle.
- Priority per edge: rst > flush > accept > hold/drain.
  - flush=1 -> out_valid=0, incoming instruction discarded.
  - No accept and out_ready=1 -> out_valid=0.
  - out_valid && !out_ready -> all outputs held bit-stable.
- While out_valid=0, all enable outputs (reg_write, mem_*, branch, jump, jalr, link, illegal) are 0.
- dec_count increments when out_valid && out_ready && !flush. It wraps at 2^CNT_W.
- Opcode decode:
  - R 0110011: reg_write, mem_to_reg.
  - I-ALU 0010011: alu_src, reg_write, mem_to_reg.
  - LOAD 0000011: alu_src, mem_read, reg_write, mem_to_reg=0, size/unsigned from funct3 (011, 110, 111 illegal).
  - STORE 0100011: alu_src, mem_write, funct3>010 illegal.
  - BRANCH 1100011: branch, br_funct3, alu_cnt SUB for 000/001, SLT for 100/101, SLTU for 110/111; 010/011 illegal.
  - JAL 1101111: jump, link, alu_src_pc, alu_src, ADD.
  - JALR 1100111: jalr, link, alu_src, ADD; funct3!=000 illegal.
  - LUI 0110111: alu_src, reg_write, alu_cnt PASSB.
  - AUIPC 0010111: alu_src_pc, alu_src, reg_write, ADD.
  - Any other opcode: illegal.
- Illegal: illegal=1, out_valid=1, all other enables 0. No X/Z is ever driven.
- alu_cnt codes (base codes keep bit4=0):
  - AND 00000, OR 00001, ADD 00010, PASSB 00011, SUB 00110, SLT 00111, SRA 01000, SLTU 01001, XOR 01100, SLL 01101, SRL 01110.
  - With ENABLE_M: MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- R-type funct7 must be 0000000, or 0100000 only for ADD->SUB and SRL->SRA. Otherwise the instruction is illegal, unless ENABLE_M && funct7=0000001.
- I-type shifts: imm[11:5] must be 0000000, or 0100000 for SRAI. Otherwise illegal.
- The immediate is sign-extended from instr[31] to XLEN. B/J immediates have bit0=0.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, dec_count=0, all enables 0; first accept after release appears 1 cycle later.
- Decode sweep (ADDI x1,x0,-1 = 0xFFF00093, pc=0x100) -> cycle+1: out_valid=1, imm=0xFFFFFFFF, alu_cnt=00010, alu_src=1, reg_write=1, rd=1, out_pc=0x100. BLTU 0x0020E463 -> branch=1, br_funct3=110, alu_cnt=01001, imm=8.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs bit-stable; out_ready=1 -> next instruction loads same edge, dec_count+1.
- Flush: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, neither instruction appears, dec_count unchanged.
- Illegal: MUL 0x02208033 with ENABLE_M=0 -> illegal=1, reg_write=0; with ENABLE_M=1 -> alu_cnt=10000, illegal=0. Opcode 0x7F -> illegal=1.
- Counter wrap (CNT_W=4): 17 back-to-back accepted transfers -> dec_count=1.
